// File: rtl/cpu_bus_responder_if.sv
// CPU external bus, responder view.
// bus_en  : qualifies a bus cycle on the rising clock edge
// addr    : 16-bit CPU address
// r_nw    : 1 = read, 0 = write
// data_wr : write data from the CPU
// data_rd : registered read data back to the CPU
interface cpu_bus_responder_if;
  logic        bus_en;
  logic [15:0] addr;
  logic        r_nw;
  logic [7:0]  data_wr;
  logic [7:0]  data_rd;

  modport master (
    output bus_en, addr, r_nw, data_wr,
    input  data_rd
  );

  modport slave (
    input  bus_en, addr, r_nw, data_wr,
    output data_rd
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// Responder for the CPU external bus: mirrored work RAM at $0000-$1FFF,
// two serial controller ports at $4016/$4017, and an open-bus latch that
// answers every other address with the last value seen on the bus.
// Ports:
//   clk          : system clock, all updates on the rising edge
//   rst          : asynchronous active-low reset
//   bus          : CPU bus (slave modport), data_rd is registered
//   pad1_buttons : controller 1 live buttons (bit0=A ... bit7=Right, 1=pressed)
//   pad2_buttons : controller 2 live buttons, same encoding
module cpu_bus_responder #(
  parameter int RAM_AW = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_bus_responder_if.slave    bus,
  input  logic [7:0]            pad1_buttons,
  input  logic [7:0]            pad2_buttons
);

  logic [7:0]        mem [0:(1<<RAM_AW)-1];
  logic [7:0]        open_bus;
  logic [7:0]        sh1;
  logic [7:0]        sh2;
  logic              strobe;

  logic              sel_ram;
  logic              sel_pad1;
  logic              sel_pad2;
  logic [RAM_AW-1:0] idx;
  logic [7:0]        rd_next;

  // Controller read word: only bit0 carries data, the top three bits float
  // from the open-bus latch and the middle bits read as zero.
  function automatic logic [7:0] pad_word(input logic [7:0] ob, input logic b);
    return {ob[7:5], 4'b0000, b};
  endfunction

  always_comb begin
    sel_ram  = (bus.addr[15:13] == 3'b000);
    sel_pad1 = (bus.addr == 16'h4016);
    sel_pad2 = (bus.addr == 16'h4017);
    // Upper address bits are dropped here, which produces the RAM mirrors.
    idx      = bus.addr[RAM_AW-1:0];

    rd_next = open_bus;
    if (sel_ram)
      rd_next = mem[idx];
    else if (sel_pad1)
      rd_next = pad_word(open_bus, strobe ? pad1_buttons[0] : sh1[0]);
    else if (sel_pad2)
      rd_next = pad_word(open_bus, strobe ? pad2_buttons[0] : sh2[0]);
  end

  // RAM has no reset value; holding reset simply blocks any write so a
  // cycle caught by reset assertion leaves the array untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (rst && bus.bus_en && !bus.r_nw && sel_ram)
      mem[idx] <= bus.data_wr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.data_rd <= 8'h00;
      open_bus    <= 8'h00;
      strobe      <= 1'b0;
      sh1         <= 8'hFF;
      sh2         <= 8'hFF;
    end else begin
      // Reload runs every clock while strobe is high, regardless of bus_en.
      // A strobe write in this same cycle only takes effect next edge.
      if (strobe) begin
        sh1 <= pad1_buttons;
        sh2 <= pad2_buttons;
      end

      if (bus.bus_en) begin
        if (bus.r_nw) begin
          bus.data_rd <= rd_next;
          open_bus    <= rd_next;
          // Shift in ones so reads past the eighth button return 1.
          if (!strobe && sel_pad1)
            sh1 <= {1'b1, sh1[7:1]};
          if (!strobe && sel_pad2)
            sh2 <= {1'b1, sh2[7:1]};
        end else begin
          open_bus <= bus.data_wr;
          if (sel_pad1)
            strobe <= bus.data_wr[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

  logic       clk;
  logic       rst;
  logic [7:0] pad1;
  logic [7:0] pad2;

  cpu_bus_responder_if bus ();

  cpu_bus_responder #(.RAM_AW(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .pad1_buttons (pad1),
    .pad2_buttons (pad2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: RAM as a plain byte array, controllers as a latched
  // button snapshot plus a count of serial reads taken since that snapshot.
  logic [7:0] m_ram [2048];
  logic [7:0] m_rd;
  logic [7:0] m_ob;
  logic       m_strobe;
  logic [7:0] m_lat1, m_lat2;
  int         m_cnt1, m_cnt2;

  function automatic logic pad_bit(input logic [7:0] lat, input int cnt);
    return (cnt < 8) ? lat[cnt] : 1'b1;
  endfunction

  task automatic model_reset();
    m_rd = 8'h00; m_ob = 8'h00; m_strobe = 1'b0;
    m_lat1 = 8'hFF; m_lat2 = 8'hFF; m_cnt1 = 8; m_cnt2 = 8;
  endtask

  task automatic model_edge();
    logic       old_strobe;
    logic [7:0] v;
    int         a;
    old_strobe = m_strobe;
    a = int'(bus.addr);
    if (bus.bus_en) begin
      if (bus.r_nw) begin
        if (a < 'h2000) v = m_ram[a % 2048];
        else if (a == 'h4016) begin
          v = {m_ob[7:5], 4'b0000, old_strobe ? pad1[0] : pad_bit(m_lat1, m_cnt1)};
          if (!old_strobe && m_cnt1 < 8) m_cnt1++;
        end else if (a == 'h4017) begin
          v = {m_ob[7:5], 4'b0000, old_strobe ? pad2[0] : pad_bit(m_lat2, m_cnt2)};
          if (!old_strobe && m_cnt2 < 8) m_cnt2++;
        end else v = m_ob;
        m_rd = v;
        m_ob = v;
      end else begin
        if (a < 'h2000) m_ram[a % 2048] = bus.data_wr;
        if (a == 'h4016) m_strobe = bus.data_wr[0];
        m_ob = bus.data_wr;
      end
    end
    if (old_strobe) begin
      m_lat1 = pad1; m_lat2 = pad2; m_cnt1 = 0; m_cnt2 = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic [15:0] a, input logic rnw, input logic [7:0] d);
    bus.bus_en = en; bus.addr = a; bus.r_nw = rnw; bus.data_wr = d;
    @(posedge clk);
    if (rst) model_edge(); else model_reset();
    #1;
    chk("data_rd_model", bus.data_rd, m_rd);
  endtask

  logic [8:0]  seq1;
  logic [2:0]  seq2;
  logic [7:0]  tmp;
  logic [15:0] ra;

  initial begin
    rst = 1'b1; pad1 = 8'h00; pad2 = 8'h00;
    bus.bus_en = 1'b0; bus.addr = 16'h0000; bus.r_nw = 1'b1; bus.data_wr = 8'h00;
    model_reset();
    #2 rst = 1'b0;
    #1 chk("reset_data_rd", bus.data_rd, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;

    // Fill RAM so every later read has a defined value.
    for (int i = 0; i < 2048; i++) step(1'b1, 16'(i), 1'b0, 8'($urandom));

    // Mirroring
    step(1'b1, 16'h0000, 1'b0, 8'h5A);
    step(1'b1, 16'h0800, 1'b1, 8'h00); chk("mirror_0800", bus.data_rd, 8'h5A);
    step(1'b1, 16'h1000, 1'b1, 8'h00); chk("mirror_1000", bus.data_rd, 8'h5A);
    step(1'b1, 16'h1800, 1'b1, 8'h00); chk("mirror_1800", bus.data_rd, 8'h5A);
    step(1'b1, 16'h07FF, 1'b0, 8'h33);
    step(1'b1, 16'h1FFF, 1'b1, 8'h00); chk("mirror_1fff", bus.data_rd, 8'h33);

    // Controller shift
    pad1 = 8'b1000_0001; pad2 = 8'b0000_0110;
    step(1'b1, 16'h4016, 1'b0, 8'h01);
    step(1'b1, 16'h4016, 1'b0, 8'h00);
    seq1 = 9'b1_1000_0001;
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 16'h4016, 1'b1, 8'h00);
      chk($sformatf("pad1_bit%0d", k), bus.data_rd, {7'b0, seq1[k]});
    end
    seq2 = 3'b110;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 16'h4017, 1'b1, 8'h00);
      chk($sformatf("pad2_bit%0d", k), bus.data_rd, {7'b0, seq2[k]});
    end

    // Strobe held: reads follow the live A button without shifting
    step(1'b1, 16'h4016, 1'b0, 8'h01);
    pad1 = 8'h01;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 16'h4016, 1'b1, 8'h00);
      chk("strobe_held_a1", bus.data_rd, 8'h01);
    end
    pad1 = 8'h00;
    step(1'b1, 16'h4016, 1'b1, 8'h00); chk("strobe_held_a0", bus.data_rd, 8'h00);
    step(1'b1, 16'h4016, 1'b0, 8'h00);

    // Open bus
    step(1'b1, 16'h0000, 1'b1, 8'h00); chk("ob_ram0", bus.data_rd, 8'h5A);
    step(1'b1, 16'h5000, 1'b1, 8'h00); chk("ob_5000", bus.data_rd, 8'h5A);
    step(1'b1, 16'h3000, 1'b0, 8'h77);
    step(1'b1, 16'h3000, 1'b1, 8'h00); chk("ob_3000", bus.data_rd, 8'h77);
    step(1'b1, 16'h6000, 1'b0, 8'h40);
    step(1'b1, 16'h4017, 1'b1, 8'h00);
    tmp = {5'b0, bus.data_rd[7:5]};
    chk("ob_pad_upper", tmp, 8'h02);

    // Qualifier: a dead cycle must not write RAM or touch data_rd
    step(1'b1, 16'h0010, 1'b0, 8'h21);
    step(1'b1, 16'h5555, 1'b1, 8'h00);
    tmp = bus.data_rd;
    step(1'b0, 16'h0010, 1'b0, 8'hFF); chk("qual_hold", bus.data_rd, tmp);
    step(1'b1, 16'h0010, 1'b1, 8'h00); chk("qual_ram", bus.data_rd, 8'h21);

    // Mid-cycle reset, with a RAM write caught under reset
    step(1'b1, 16'h0000, 1'b1, 8'h00);
    #3 rst = 1'b0;
    #1 chk("midreset_data_rd", bus.data_rd, 8'h00);
    model_reset();
    step(1'b1, 16'h0000, 1'b0, 8'hEE);
    rst = 1'b1;
    step(1'b1, 16'h4016, 1'b1, 8'h00); chk("post_reset_pad", bus.data_rd, 8'h01);
    step(1'b1, 16'h0000, 1'b1, 8'h00); chk("reset_drop_write", bus.data_rd, 8'h5A);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) pad1 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) pad2 = 8'($urandom);
      case ($urandom_range(0, 5))
        0, 1: ra = 16'($urandom_range(0, 16'h1FFF));
        2:    ra = 16'h4016;
        3:    ra = 16'h4017;
        default: ra = 16'($urandom);
      endcase
      step(($urandom_range(0, 4) != 0), ra, ($urandom_range(0, 2) != 0), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Responder side of the CPU's external bus. Decodes each CPU cycle's address and read/write strobe and returns read data or commits writes. It serves the 2 KB work RAM, which is mirrored across $0000-$1FFF. It also serves the two serial controller ports at $4016/$4017 with a strobe latch and shift registers, and holds an open-bus latch for every unmapped address.

## Interface
Parameters:
- RAM_AW, 11, work-RAM address width (2^RAM_AW bytes); mirrored across $0000-$1FFF.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- bus_en  in  1  qualifies a CPU bus cycle; no state changes when 0.
- addr  in  16  CPU address bus.
- r_nw  in  1  1 = read, 0 = write.
- data_wr  in  8  CPU output data bus (write data).
- data_rd  out  8  read data to CPU input data bus, registered.
- pad1_buttons  in  8  controller 1 live buttons, bit0=A, bit1=B, bit2=Select, bit3=Start, bit4=Up, bit5=Down, bit6=Left, bit7=Right; 1 = pressed.
- pad2_buttons  in  8  controller 2, same encoding.

## Operation
- Address decode on edges where bus_en=1:
  - RAM: addr[15:13]==3'b000. Index is addr[RAM_AW-1:0]; upper bits ignored, which gives the mirroring.
  - PAD1: addr==$4016.
  - PAD2: addr==$4017.
  - OPEN: every other address.
- RAM write: mem[idx] <= data_wr.
- RAM read: data_rd <= mem[idx].
- Write to $4016: strobe <= data_wr[0]. Writes to $4017 and to OPEN are ignored.
- Strobe behaviour:
  - While strobe=1, both shift registers reload from pad*_buttons every clk, independent of bus_en.
  - The first clk with strobe=0 keeps the last loaded value.
- PADn read, strobe=0:
  - data_rd <= {open_bus[7:5], 4'b0000, shN[0]}.
  - shN <= {1'b1, shN[7:1]}: shift right, fill with 1.
  - After 8 reads, every further read returns bit0=1 until the next reload.
- PADn read, strobe=1: returns pad*_buttons[0] for the current cycle, with no shift.
- OPEN read: data_rd <= open_bus.
- open_bus latch, on every bus_en=1 edge:
  - reads: takes the value being loaded into data_rd.
  - writes: takes data_wr.
- Write cycles: data_rd holds its previous value.
- Reset values: data_rd=8'h00, open_bus=8'h00, strobe=0, sh1=sh2=8'hFF. RAM contents are not reset (undefined).
- Reset mid-operation: reset takes effect immediately (async). A write in flight at reset assertion is dropped; RAM keeps its prior contents.

## Timing
- A request is sampled at rising edge N with bus_en=1.
- Read data appears on data_rd after edge N: 1-cycle latency. It is held until the next bus_en=1 read.
- A write commits at edge N. A read of the same location sampled at N+1 returns the new value.
- Write $4016=1 at edge N: shift registers hold pad values from edge N+1.
- A $4016 write and a reload in the same cycle: the new strobe value governs from the next edge.
- A read of $4016 sampled at edge N shifts at edge N. The read at N+1 sees the next bit, so back-to-back reads are allowed every cycle.
- Reads of $4016 never shift sh2, and reads of $4017 never shift sh1.
- bus_en=0: data_rd, open_bus, RAM and the shift registers hold. The one exception is the strobe=1 reload.

## Test plan
- Reset: assert rst=0 mid-cycle -> data_rd=8'h00 immediately. After release, read $4016 with strobe=0 -> 8'h01.
- Mirroring: write $0000=8'h5A, then read $0800, $1000 and $1800 -> 8'h5A each. Write $07FF=8'h33, then read $1FFF -> 8'h33.
- Controller shift: pad1=8'b1000_0001.
  - Write $4016=1, then write $4016=0.
  - Nine consecutive reads of $4016 -> bit0 sequence 1,0,0,0,0,0,0,1,1; data_rd[4:1]=0.
  - pad2 reads are unaffected.
- Strobe held: write $4016=1, set pad1[0]=1, do 5 reads -> all bit0=1. Then toggle pad1[0]=0 -> the next read bit0=0.
- Open bus: read $0000 (8'h5A), then read $5000 -> 8'h5A. Write $3000... Write $6000=8'h40, then read $4017 -> upper bits [7:5]=3'b010.
- Qualifier: drive addr=$0010, r_nw=0, data_wr=8'hFF with bus_en=0, then read $0010 with bus_en=1 -> prior value unchanged; data_rd unchanged during the bus_en=0 cycle.
